sync_irq_gateway: RTL and testbench

Per-source interrupt gateway that sits directly downstream of the 2-bit synchronizer shift register on asynchronous interrupt lines. It consumes the synchronized source levels and converts each into a single outstanding request toward the interrupt controller, with a request/accept handshake and a completion return. Each source operates in either level mode or edge mode; edge mode keeps a saturating count of pending edges.

---
 rtl/sync_irq_gateway.sv | 126 ++++++++++++
 tb/tb_sync_irq_gateway.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_irq_gateway.sv
// Per-source interrupt gateway: turns synchronized interrupt levels/edges into
// a single outstanding request with accept handshake and completion return.
module sync_irq_gateway #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_SRC-1:0]       src_sync,
  input  logic [N_SRC-1:0]       edge_mode,
  input  logic [N_SRC-1:0]       enable,
  output logic [N_SRC-1:0]       req_valid,
  input  logic [N_SRC-1:0]       req_ready,
  input  logic [N_SRC-1:0]       complete,
  output logic [N_SRC-1:0]       in_flight,
  output logic [N_SRC*CNT_W-1:0] pend_cnt,
  output logic [N_SRC-1:0]       overflow,
  input  logic                   overflow_clr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q [N_SRC];
  state_e           state_d [N_SRC];
  logic [CNT_W-1:0] cnt_q   [N_SRC];
  logic [CNT_W-1:0] cnt_d   [N_SRC];

  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] ovf_q;
  logic [N_SRC-1:0] ovf_d;
  logic [N_SRC-1:0] req_valid_q;
  logic [N_SRC-1:0] in_flight_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] count_edge;
  logic [N_SRC-1:0] accept;
  logic [N_SRC-1:0] consume;
  logic [N_SRC-1:0] ovf_set;

  assign rise       = src_sync & ~prev_q;
  assign count_edge = rise & enable & edge_mode;

  always_comb begin
    accept  = '0;
    consume = '0;
    ovf_set = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      accept[i]  = (state_q[i] == ST_REQ) && req_ready[i];
      consume[i] = accept[i] && edge_mode[i] && (cnt_q[i] != '0);

      // A counted edge and a consumed request in the same cycle cancel out,
      // so the counter cannot be saturated by that edge.
      if (count_edge[i] && !consume[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (consume[i] && !count_edge[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end

      unique case (state_q[i])
        ST_IDLE: begin
          if (enable[i] && (edge_mode[i] ? (cnt_q[i] != '0) : src_sync[i])) begin
            state_d[i] = ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_ready[i]) begin
            state_d[i] = ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (complete[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
    ovf_d = (ovf_q & ~{N_SRC{overflow_clr}}) | ovf_set;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      prev_q      <= '0;
      ovf_q       <= '0;
      req_valid_q <= '0;
      in_flight_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        state_q[i]     <= state_d[i];
        cnt_q[i]       <= cnt_d[i];
        req_valid_q[i] <= (state_d[i] == ST_REQ);
        in_flight_q[i] <= (state_d[i] == ST_SERVICE);
      end
      prev_q <= src_sync;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      pend_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign req_valid = req_valid_q;
  assign in_flight = in_flight_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sync_irq_gateway.sv
// Directed bench for sync_irq_gateway: a per-cycle behavioural model plus
// hand-computed expectations at key points of each scenario.
module tb_sync_irq_gateway;

  logic       clock;
  logic       reset_n;
  logic [1:0] src_sync;
  logic [1:0] edge_mode;
  logic [1:0] enable;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] complete;
  logic [1:0] in_flight;
  logic [3:0] pend_cnt;
  logic [1:0] overflow;
  logic       overflow_clr;

  int checks   = 0;
  int failures = 0;

  sync_irq_gateway #(.N_SRC(2), .CNT_W(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .src_sync     (src_sync),
    .edge_mode    (edge_mode),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .complete     (complete),
    .in_flight    (in_flight),
    .pend_cnt     (pend_cnt),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: per source, "asking" = request raised but not accepted,
  // "owned" = accepted and not completed, plus an integer edge backlog.
  bit m_asking [2];
  bit m_owned  [2];
  int m_pend   [2];
  bit m_ovf    [2];
  bit m_last   [2];

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_asking[i] = 0; m_owned[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; m_last[i] = 0;
      end else begin
        bit counted, taken, grows, sat;
        int backlog;
        backlog = m_pend[i];
        counted = src_sync[i] && !m_last[i] && enable[i] && edge_mode[i];
        taken   = m_asking[i] && req_ready[i] && edge_mode[i] && backlog > 0;
        grows   = counted && !taken;
        sat     = grows && backlog == 3;
        m_pend[i] = backlog + ((grows && !sat) ? 1 : 0) - ((taken && !counted) ? 1 : 0);
        m_ovf[i]  = sat || (m_ovf[i] && !overflow_clr);
        if (m_asking[i]) begin
          if (req_ready[i]) begin m_asking[i] = 0; m_owned[i] = 1; end
        end else if (m_owned[i]) begin
          if (complete[i]) m_owned[i] = 0;
        end else if (enable[i] && (edge_mode[i] ? backlog > 0 : src_sync[i] == 1'b1)) begin
          m_asking[i] = 1;
        end
        m_last[i] = src_sync[i];
      end
    end
  endtask

  initial begin
    forever begin
      logic [1:0] e_rv, e_if, e_ov;
      logic [3:0] e_pc;
      @(posedge clock);
      model_edge();
      #1;
      e_rv = {m_asking[1], m_asking[0]};
      e_if = {m_owned[1], m_owned[0]};
      e_ov = {m_ovf[1], m_ovf[0]};
      e_pc = {m_pend[1][1:0], m_pend[0][1:0]};
      checks++;
      if ({req_valid, in_flight, pend_cnt, overflow} !== {e_rv, e_if, e_pc, e_ov}) begin
        failures++;
        $display("FAIL model t=%0t rv=%b/%b if=%b/%b pc=%h/%h ov=%b/%b (actual/required)",
                 $time, req_valid, e_rv, in_flight, e_if, pend_cnt, e_pc, overflow, e_ov);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 0; src_sync = 2'b11; edge_mode = 2'b00; enable = 2'b11;
    req_ready = 0; complete = 0; overflow_clr = 0;

    // Reset with sources high, then level-mode release.
    tick(3);
    chk("rst_rv",  {6'd0, req_valid}, 8'b00);
    chk("rst_if",  {6'd0, in_flight}, 8'b00);
    chk("rst_pc",  {4'd0, pend_cnt},  8'h00);
    chk("rst_ovf", {6'd0, overflow},  8'b00);
    reset_n = 1;
    tick();
    chk("rel_rv", {6'd0, req_valid}, 8'b11);
    req_ready = 2'b11; tick(); req_ready = 0;
    chk("rel_if", {6'd0, in_flight}, 8'b11);
    src_sync = 0; complete = 2'b11; tick(); complete = 0;
    chk("rel_done", {4'd0, req_valid, in_flight}, 8'b0000);
    tick();

    // Level handshake on source 0.
    enable = 2'b01; src_sync = 2'b01;
    tick();
    chk("lvl_rv", {6'd0, req_valid}, 8'b01);
    tick(2);
    chk("lvl_rv_wait", {6'd0, req_valid}, 8'b01);
    req_ready = 2'b01; tick(); req_ready = 0;
    chk("lvl_acc", {4'd0, req_valid, in_flight}, 8'b0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lvl_inflight", {6'd0, in_flight}, 8'b01);
    end
    complete = 2'b01; tick(); complete = 0;
    chk("lvl_cmp", {4'd0, req_valid, in_flight}, 8'b0000);
    tick();
    chk("lvl_rereq", {6'd0, req_valid}, 8'b01);
    src_sync = 0; req_ready = 2'b01; tick(); req_ready = 0;
    complete = 2'b01; tick(); complete = 0;
    tick();
    chk("lvl_idle", {4'd0, req_valid, in_flight}, 8'b0000);

    // Edge counting and saturation on source 1.
    edge_mode = 2'b10; enable = 2'b10; src_sync = 2'b10;
    tick();
    chk("edg_pc1", {4'd0, pend_cnt}, 8'b0100);
    chk("edg_norv", {6'd0, req_valid}, 8'b00);
    tick();
    chk("edg_rv", {6'd0, req_valid}, 8'b10);
    req_ready = 2'b10; tick(); req_ready = 0;
    chk("edg_acc", {2'd0, in_flight, pend_cnt}, 8'b100000);
    for (int k = 0; k < 4; k++) begin
      src_sync = 2'b00; tick();
      src_sync = 2'b10; tick();
    end
    chk("edg_sat", {2'd0, overflow, pend_cnt}, 8'b101100);
    for (int r = 0; r < 3; r++) begin
      complete = 2'b10; tick(); complete = 0;
      tick();
      chk("edg_round_rv", {6'd0, req_valid}, 8'b10);
      req_ready = 2'b10; tick(); req_ready = 0;
    end
    chk("edg_drained", {4'd0, pend_cnt}, 8'h00);
    complete = 2'b10; tick(); complete = 0;
    tick(2);
    chk("edg_no4th", {4'd0, req_valid, in_flight}, 8'b0000);
    src_sync = 0; tick();

    // Rise coinciding with accept: count holds at 1.
    src_sync = 2'b10; tick();
    src_sync = 2'b00; tick();
    chk("sim_rv", {2'd0, req_valid, pend_cnt}, 8'b100100);
    src_sync = 2'b10; req_ready = 2'b10; tick(); req_ready = 0;
    chk("sim_hold", {2'd0, in_flight, pend_cnt}, 8'b100100);
    complete = 2'b10; tick(); complete = 0;
    tick();
    req_ready = 2'b10; tick(); req_ready = 0;
    complete = 2'b10; tick(); complete = 0;
    src_sync = 0; tick();

    // Latched request survives source drop and enable drop.
    edge_mode = 2'b10; enable = 2'b11; src_sync = 2'b01;
    tick();
    src_sync = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 9) chk("lat_hold", {6'd0, req_valid}, 8'b01);
    end
    enable = 2'b10; tick();
    chk("lat_endrop", {6'd0, req_valid}, 8'b01);
    req_ready = 2'b01; tick(); req_ready = 0;
    chk("lat_acc", {4'd0, req_valid, in_flight}, 8'b0001);
    complete = 2'b01; tick(); complete = 0;

    // Stray complete/ready and overflow clear ordering.
    enable = 2'b11; complete = 2'b01; req_ready = 2'b01; tick();
    complete = 0; req_ready = 0;
    chk("stray_idle", {4'd0, req_valid, in_flight}, 8'b0000);
    src_sync = 2'b01; tick();
    complete = 2'b01; tick(); complete = 0;
    chk("stray_req", {4'd0, req_valid, in_flight}, 8'b0100);
    req_ready = 2'b01; src_sync = 0; tick(); req_ready = 0;
    complete = 2'b01; tick(); complete = 0;
    overflow_clr = 1; tick(); overflow_clr = 0;
    chk("ovf_clr", {6'd0, overflow}, 8'b00);
    src_sync = 2'b10; tick();
    src_sync = 2'b00; tick();
    req_ready = 2'b10; tick(); req_ready = 0;
    for (int k = 0; k < 3; k++) begin
      src_sync = 2'b10; tick();
      src_sync = 2'b00; tick();
    end
    chk("ovf_pre", {2'd0, overflow, pend_cnt}, 8'b001100);
    src_sync = 2'b10; overflow_clr = 1; tick(); overflow_clr = 0;
    chk("ovf_setwins", {6'd0, overflow}, 8'b10);
    src_sync = 0; tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
